// File: rtl/rot_pkg.sv
// Shared definitions for the rotate sequencer: default widths and FSM encoding.
package rot_pkg;

  localparam int DW_DEF = 4;
  localparam int CW_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ROT  = 3'd2,
    ST_CAPT = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/rotate_seq_ctrl_if.sv
// Request/result handshake bundle between a requester and the rotate sequencer.
interface rotate_seq_ctrl_if #(
  parameter int DW = rot_pkg::DW_DEF,
  parameter int CW = rot_pkg::CW_DEF
);

  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_data;
  logic [CW-1:0] req_count;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;

  modport master (
    output req_valid, req_data, req_count, res_ready,
    input  req_ready, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_data, req_count, res_ready,
    output req_ready, res_valid, res_data
  );

endinterface

// File: rtl/rot_down_cnt.sv
// Loadable down-counter with zero flag; tracks remaining rotate cycles.
module rot_down_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (i_dec && !o_zero)
      r_cnt <= r_cnt - CW'(1);
  end

endmodule

// File: rtl/rotate_seq_ctrl.sv
// Sequencer driving a left-rotate register: load once, rotate N times,
// capture q and return it over the result handshake.
//
//   state | meaning
//   IDLE  | ready for a request; latches pattern/count on accept
//   LOAD  | load=1, register takes the latched pattern
//   ROT   | en=1, one left rotation per cycle until the counter reads 1
//   CAPT  | register holds; res_data captures q
//   RESP  | res_valid=1 until res_ready
module rotate_seq_ctrl import rot_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                clk,
  input  logic                async_rst,
  rotate_seq_ctrl_if.slave    bus,
  output logic                load,
  output logic                en,
  output logic [DW-1:0]       data,
  input  logic [DW-1:0]       q,
  output logic                busy
);

  state_e        r_state;
  state_e        w_next;
  logic [DW-1:0] r_pattern;
  logic [DW-1:0] r_res_data;
  logic [CW-1:0] w_cnt;
  logic          w_cnt_zero;
  logic          w_accept;

  assign w_accept     = (r_state == ST_IDLE) && bus.req_valid;
  assign data         = r_pattern;
  assign bus.res_data = r_res_data;

  rot_down_cnt #(.CW(CW)) u_cnt (
    .clk        (clk),
    .async_rst  (async_rst),
    .i_load     (w_accept),
    .i_load_val (bus.req_count),
    .i_dec      (r_state == ST_ROT),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; counter already holds N while in LOAD.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.req_valid) w_next = ST_LOAD;
      ST_LOAD: w_next = w_cnt_zero ? ST_CAPT : ST_ROT;
      ST_ROT:  if (w_cnt == CW'(1)) w_next = ST_CAPT;
      ST_CAPT: w_next = ST_RESP;
      ST_RESP: if (bus.res_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are pure state decodes, so no input reaches an output combinationally.
  always_comb begin
    load          = 1'b0;
    en            = 1'b0;
    busy          = 1'b1;
    bus.req_ready = 1'b0;
    bus.res_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy          = 1'b0;
        bus.req_ready = 1'b1;
      end
      ST_LOAD: load          = 1'b1;
      ST_ROT:  en            = 1'b1;
      ST_RESP: bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  // Pattern latched only at accept; result captured only in CAPT.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_pattern  <= '0;
      r_res_data <= '0;
    end else begin
      if (w_accept)
        r_pattern <= bus.req_data;
      if (r_state == ST_CAPT)
        r_res_data <= q;
    end
  end

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Bench for rotate_seq_ctrl wired to a behavioural left-rotate register.
module tb_rotate_seq_ctrl;

  localparam int DW = 4;
  localparam int CW = 3;

  logic          clk;
  logic          async_rst;
  logic          load;
  logic          en;
  logic [DW-1:0] data;
  logic [DW-1:0] q;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int tot_load = 0;
  int tot_en   = 0;
  int viol     = 0;

  rotate_seq_ctrl_if #(.DW(DW), .CW(CW)) bus ();

  rotate_seq_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .bus       (bus),
    .load      (load),
    .en        (en),
    .data      (data),
    .q         (q),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate register stage sharing clock and reset with the controller.
  always @(posedge clk or posedge async_rst) begin
    if (async_rst)    q <= '0;
    else if (load)    q <= data;
    else if (en)      q <= {q[DW-2:0], q[DW-1]};
  end

  // Cycle monitor: cumulative load/en cycles and load&en overlap.
  always @(negedge clk) begin
    if (load) tot_load <= tot_load + 1;
    if (en)   tot_en   <= tot_en + 1;
    if (load && en) viol <= viol + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_rot(input int p, input int c);
    int k;
    k = c % DW;
    return ((p << k) | (p >> (DW - k))) & ((1 << DW) - 1);
  endfunction

  // One full transaction; res_ready held low for rr_delay cycles in RESP.
  task automatic do_txn(input logic [DW-1:0] p, input logic [CW-1:0] c, input int rr_delay,
                        output int res, output int lat, output int n_ld, output int n_en);
    int t;
    int ld0;
    int en0;
    res = -1; lat = -1; n_ld = -1; n_en = -1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_data  = p;
    bus.req_count = c;
    bus.res_ready = (rr_delay == 0);
    t = 0;
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    ld0 = tot_load;
    en0 = tot_en;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_data  = 4'($urandom_range(15));
    bus.req_count = 3'($urandom_range(7));
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.res_valid) break;
    end
    if (!bus.res_valid) begin
      check("result_timeout", 0, 1);
      return;
    end
    n_ld = tot_load - ld0;
    n_en = tot_en - en0;
    res  = int'(bus.res_data);
    for (int i = 0; i < rr_delay; i++) begin
      @(negedge clk);
      check("res_hold_stable", int'(bus.res_data), res);
      check("res_hold_valid", int'(bus.res_valid), 1);
    end
    if (rr_delay > 0) bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_handshake_valid", int'(bus.res_valid), 0);
  endtask

  typedef struct {
    logic [DW-1:0] p;
    logic [CW-1:0] c;
    logic [DW-1:0] exp;
    int            lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int res, lat, n_ld, n_en, t;
    logic [DW-1:0] rp;
    logic [CW-1:0] rc;
    int rd;

    vecs[0] = '{4'b0011, 3'd1, 4'b0110, 3};
    vecs[1] = '{4'b1001, 3'd3, 4'b1100, 5};
    vecs[2] = '{4'b1001, 3'd4, 4'b1001, 6};
    vecs[3] = '{4'b1001, 3'd7, 4'b1100, 9};
    vecs[4] = '{4'b1010, 3'd0, 4'b1010, 2};

    async_rst     = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.req_count = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    async_rst = 1'b0;
    @(negedge clk);
    check("rst_load", int'(load), 0);
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_res_data", int'(bus.res_data), 0);
    check("rst_data", int'(data), 0);

    // Directed vectors from the table.
    for (int i = 0; i < 5; i++) begin
      do_txn(vecs[i].p, vecs[i].c, 0, res, lat, n_ld, n_en);
      check("vec_res", res, int'(vecs[i].exp));
      check("vec_latency", lat, vecs[i].lat);
      check("vec_load_cycles", n_ld, 1);
      check("vec_en_cycles", n_en, int'(vecs[i].c));
      check("vec_data_held", int'(data), int'(vecs[i].p));
    end

    // Result back-pressure with a competing request waiting.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_data  = 4'b0110;
    bus.req_count = 3'd2;
    bus.res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_data  = 4'b1110;
    bus.req_count = 3'd1;
    t = 0;
    while (!bus.res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("hold_res_valid", int'(bus.res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_res_data", int'(bus.res_data), 4'b1001);
      check("hold_req_ready", int'(bus.req_ready), 0);
      check("hold_no_load", int'(load), 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hs_idle_res_valid", int'(bus.res_valid), 0);
    check("hs_idle_req_ready", int'(bus.req_ready), 1);
    check("hs_idle_no_load", int'(load), 0);
    @(posedge clk);
    @(negedge clk);
    check("second_load", int'(load), 1);
    check("second_data", int'(data), 4'b1110);
    bus.req_valid = 1'b0;
    t = 0;
    while (!bus.res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("second_res", int'(bus.res_data), 4'b1101);
    @(posedge clk);

    // Reset in the middle of rotation.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_data  = 4'b0001;
    bus.req_count = 3'd6;
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrot_q", int'(q), 4'b0100);
    check("midrot_en", int'(en), 1);
    #1;
    async_rst = 1'b1;
    #1;
    check("arst_load", int'(load), 0);
    check("arst_en", int'(en), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_res_valid", int'(bus.res_valid), 0);
    check("arst_res_data", int'(bus.res_data), 0);
    check("arst_data", int'(data), 0);
    check("arst_q", int'(q), 0);
    check("arst_req_ready", int'(bus.req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    async_rst = 1'b0;
    t = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.res_valid || busy) t++;
    end
    check("arst_no_result", t, 0);
    do_txn(4'b0111, 3'd5, 0, res, lat, n_ld, n_en);
    check("arst_next_res", res, 4'b1110);
    check("arst_next_lat", lat, 7);

    // Random sweep against the rotation model.
    for (int i = 0; i < 40; i++) begin
      rp = 4'($urandom_range(15));
      rc = 3'($urandom_range(7));
      rd = $urandom_range(0, 3);
      do_txn(rp, rc, rd, res, lat, n_ld, n_en);
      check("rand_res", res, ref_rot(int'(rp), int'(rc)));
      check("rand_latency", lat, int'(rc) + 2);
      check("rand_en_cycles", n_en, int'(rc));
      check("rand_load_cycles", n_ld, 1);
    end

    repeat (2) @(negedge clk);
    check("load_en_overlap", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rotate_seq_ctrl.md
# rotate_seq_ctrl

Sequencer that sits directly upstream of the left-rotate register stage. It accepts a (pattern, rotation count) request over a valid/ready handshake and drives the register's `load`, `en` and `data` inputs: one load cycle, then exactly `count` rotate cycles. It then captures the register's `q` and returns it as a result over a second valid/ready handshake. One request is in flight at a time.

## Interface
- `DW`, default 4: data width; must match the rotate register's `DW`.
- `CW`, default 3: width of the rotation count field.
- `clk` input 1: single clock, rising edge.
- `async_rst` input 1: asynchronous, active-high reset; also resets the rotate register.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept a request.
- `req_data` input DW: pattern to load.
- `req_count` input CW: number of single-bit left rotations, 0 to 2^CW-1.
- `load` output 1: to rotate register `load`.
- `en` output 1: to rotate register `en`.
- `data` output DW: to rotate register `data`.
- `q` input DW: from rotate register `q`.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer takes result.
- `res_data` output DW: captured rotated value.
- `busy` output 1: high in every state except IDLE.

## Operation
- States:
  - **IDLE:** `req_ready`=1; on `req_valid`, latch `req_data`/`req_count` and go to LOAD.
  - **LOAD:** `load`=1, `data`=latched pattern, `en`=0. Go to ROT if count≠0, else CAPT.
  - **ROT:** `en`=1, `load`=0; down-counter decrements each cycle; go to CAPT on the cycle the counter reads 1.
  - **CAPT:** `load`=`en`=0; `res_data`<=`q`; go to RESP.
  - **RESP:** `res_valid`=1 and `res_data` held stable until `res_ready`; on `res_valid&&res_ready` return to IDLE.
- `load` and `en` are never both 1. Outside LOAD and ROT both are 0, so the register holds its value.
- `data` drives the latched pattern in every state; it is 0 after reset until the first accept.
- No modulo reduction: `req_count` ≥ DW performs full physical rotations (count=DW returns the original pattern).
- `req_ready` is 0 in LOAD/ROT/CAPT/RESP. A request asserted there waits; `req_data`/`req_count` are sampled only at accept.
- A new request is not accepted in the same cycle as the result handshake. Earliest accept is the cycle after returning to IDLE.
- Reset, including mid-operation: state=IDLE, counter=0, latched pattern=0, `res_data`=0, `res_valid`=0, `load`=0, `en`=0, `busy`=0, `req_ready`=1 once reset deasserts. Any in-flight request is discarded with no result.

## Timing
- Accept at edge E0. LOAD occupies the cycle after E0; the register holds the pattern after E1.
- `en` is high for exactly N cycles (edges E2..E1+N). `q` is final after edge E1+N.
- CAPT cycle follows; `res_valid` rises after edge E2+N.
- Result latency is N+2 edges after accept; N=0 gives 2.
- Back-to-back throughput is one request per N+4 cycles when `res_ready` is held high.
- All outputs are registered or pure decodes of state; there is no combinational path from `req_*` or `res_ready` to any output.

## Structure
- Shared package `rot_pkg`: state encoding constants (IDLE, LOAD, ROT, CAPT, RESP; 3-bit binary) and default `DW`/`CW` values.
- One natural sub-module: `rot_down_cnt`, a CW-bit loadable down-counter with a zero flag. Everything else (FSM, pattern/result registers) lives in `rotate_seq_ctrl`.
- The bench instantiates `rotate_seq_ctrl` wired to the rotate register stage with shared `clk`/`async_rst`.

## Test plan
- DW=4, pattern 4'b0011, count 1, `res_ready`=1 → `res_data`=4'b0110; `res_valid` 3 edges after accept; `en` high exactly 1 cycle.
- Pattern 4'b1001, count 3 → `res_data`=4'b1100. Pattern 4'b1001, count 4 → 4'b1001 (full wrap). Count 7 → 4'b1100.
- Count 0, pattern 4'b1010 → `res_data`=4'b1010 after 2 edges; `en` never asserted; `load` high exactly 1 cycle.
- Hold `res_ready`=0 for 5 cycles in RESP with `req_valid` high and a new pattern on `req_data` → `res_data` stable, `req_ready`=0, no load. The second request is accepted the cycle after the handshake.
- Assert `async_rst` mid-ROT (pattern 4'b0001, count 6, after 2 rotations) → immediately all outputs 0, `req_ready`=1, register `q`=0, no `res_valid`. The next request completes normally.
- Random pattern/count sweep with a reference model of left rotation by count mod DW. Check every cycle that `load` and `en` are never both high.
